vargen_irq_cond: RTL and testbench

//  External-input conditioner sitting directly upstream of the vargen core: receives raw

---
 rtl/vargen_irq_cond.sv | 107 ++++++++++
 tb/tb_vargen_irq_cond.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vargen_irq_cond.sv
// External irq/portb input conditioner for the vargen core: 2-FF sync, optional debounce,
// edge detect, pending/overrun latching. Define IRQ_COND_DEBOUNCE_EN to add irq debounce.
module vargen_irq_cond #(
    parameter int unsigned          NIRQ         = 3,
    parameter int unsigned          PORTB_W      = 8,
    parameter logic [NIRQ-1:0]      IRQ_POL      = {NIRQ{1'b1}},
    parameter int unsigned          DEBOUNCE_CYC = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NIRQ-1:0]    irq_pin,
    input  logic [PORTB_W-1:0] portb_pin,
    input  logic [NIRQ-1:0]    irq_en,
    input  logic               clr_we,
    input  logic [NIRQ-1:0]    clr_mask,
    output logic [PORTB_W-1:0] portb_sync,
    output logic [NIRQ-1:0]    irq_out,
    output logic [NIRQ-1:0]    pending,
    output logic [NIRQ-1:0]    overrun
);

    logic [NIRQ-1:0]    irq_s1_q, irq_s1_d, irq_s2_q, irq_s2_d;
    logic [PORTB_W-1:0] portb_s1_q, portb_s1_d, portb_s2_q, portb_s2_d;
    logic [NIRQ-1:0]    prev_q, prev_d;
    logic [NIRQ-1:0]    pending_q, pending_d, overrun_q, overrun_d;
    logic [NIRQ-1:0]    filt, act, clr;

    always_comb begin
        irq_s1_d   = irq_pin;
        irq_s2_d   = irq_s1_q;
        portb_s1_d = portb_pin;
        portb_s2_d = portb_s1_q;
    end

`ifdef IRQ_COND_DEBOUNCE_EN
    localparam int unsigned CntW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

    logic [NIRQ-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [NIRQ-1:0]           filt_q, filt_d;

    // Filtered level only follows s2 after it has disagreed for DEBOUNCE_CYC straight clocks.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < int'(NIRQ); i++) begin
            if (irq_s2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                filt_d[i] = irq_s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = irq_s2_q;
`endif

    // Clear loses to a simultaneous edge so no event is ever dropped.
    always_comb begin
        act       = (IRQ_POL & filt & ~prev_q) | (~IRQ_POL & ~filt & prev_q);
        clr       = {NIRQ{clr_we}} & clr_mask & ~act;
        prev_d    = filt;
        pending_d = (pending_q | act) & ~clr;
        overrun_d = (overrun_q | (act & pending_q)) & ~clr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_s1_q   <= '0;
            irq_s2_q   <= '0;
            portb_s1_q <= '0;
            portb_s2_q <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
        end else begin
            irq_s1_q   <= irq_s1_d;
            irq_s2_q   <= irq_s2_d;
            portb_s1_q <= portb_s1_d;
            portb_s2_q <= portb_s2_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
        end
    end

    assign portb_sync = portb_s2_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;
    assign irq_out    = pending_q & irq_en;

endmodule

// File: tb/tb_vargen_irq_cond.sv
// Bench for vargen_irq_cond: pin-history model checked every cycle plus directed literals.
// Honours IRQ_COND_DEBOUNCE_EN the same way the design does.
`timescale 1ns/1ps
module tb_vargen_irq_cond;

    localparam int NIRQ = 3;
    localparam int PW   = 8;
    localparam int DEB  = 16;
    localparam logic [NIRQ-1:0] POL = 3'b111;
`ifdef IRQ_COND_DEBOUNCE_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [NIRQ-1:0] irq_pin = '0;
    logic [PW-1:0]   portb_pin = '0;
    logic [NIRQ-1:0] irq_en = '0;
    logic            clr_we = 1'b0;
    logic [NIRQ-1:0] clr_mask = '0;
    logic [PW-1:0]   portb_sync;
    logic [NIRQ-1:0] irq_out, pending, overrun;

    int checks = 0;
    int errors = 0;

    vargen_irq_cond #(
        .NIRQ(NIRQ), .PORTB_W(PW), .IRQ_POL(POL), .DEBOUNCE_CYC(DEB)
    ) dut (
        .clk(clk), .resetn(resetn), .irq_pin(irq_pin), .portb_pin(portb_pin),
        .irq_en(irq_en), .clr_we(clr_we), .clr_mask(clr_mask), .portb_sync(portb_sync),
        .irq_out(irq_out), .pending(pending), .overrun(overrun)
    );

    always #31.25 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: per-edge pin samples; levels derived from sample windows, not from counters.
    logic [NIRQ-1:0] ih[$];
    logic [PW-1:0]   ph[$];
    logic [NIRQ-1:0] m_pend, m_ovr, m_filt, m_prev;

    task automatic model_reset();
        ih.delete();
        ph.delete();
        for (int k = 0; k < DEB + 4; k++) begin
            ih.push_back('0);
            ph.push_back('0);
        end
        m_pend = '0;
        m_ovr  = '0;
        m_filt = '0;
        m_prev = '0;
    endtask

    task automatic model_step();
        int n;
        logic [NIRQ-1:0] lvl, was, act;
        logic all_flip;
        n = ih.size();
`ifdef IRQ_COND_DEBOUNCE_EN
        lvl = m_filt;
        was = m_prev;
`else
        lvl = ih[n-2];
        was = ih[n-3];
`endif
        act = (POL & lvl & ~was) | (~POL & ~lvl & was);
        for (int c = 0; c < NIRQ; c++) begin
            if (act[c]) begin
                if (m_pend[c]) m_ovr[c] = 1'b1;
                m_pend[c] = 1'b1;
            end else if (clr_we && clr_mask[c]) begin
                m_pend[c] = 1'b0;
                m_ovr[c]  = 1'b0;
            end
        end
`ifdef IRQ_COND_DEBOUNCE_EN
        m_prev = m_filt;
        for (int c = 0; c < NIRQ; c++) begin
            all_flip = 1'b1;
            for (int k = 0; k < DEB; k++)
                if (ih[n-2-k][c] == m_filt[c]) all_flip = 1'b0;
            if (all_flip) m_filt[c] = ~m_filt[c];
        end
`else
        all_flip = 1'b0;
`endif
        ih.push_back(irq_pin);
        ph.push_back(portb_pin);
        if (ih.size() > 64) begin
            void'(ih.pop_front());
            void'(ph.pop_front());
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_portb", 32'(portb_sync), 32'h0);
            chk("rst_pending", 32'(pending), 32'h0);
            chk("rst_overrun", 32'(overrun), 32'h0);
            chk("rst_irq_out", 32'(irq_out), 32'h0);
        end else begin
            chk("cyc_portb", 32'(portb_sync), 32'(ph[ph.size()-2]));
            chk("cyc_pending", 32'(pending), 32'(m_pend));
            chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
            chk("cyc_irq_out", 32'(irq_out), 32'(m_pend & irq_en));
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear(input logic [NIRQ-1:0] m);
        clr_we   = 1'b1;
        clr_mask = m;
        clks(1);
        clr_we   = 1'b0;
        clr_mask = '0;
    endtask

    initial begin
        // 1: reset with pins high, release
        irq_pin   = 3'b111;
        portb_pin = 8'haf;
        irq_en    = 3'b111;
        clks(3);
        chk("t1_rst_portb", 32'(portb_sync), 32'h0);
        chk("t1_rst_pending", 32'(pending), 32'h0);
        chk("t1_rst_irq_out", 32'(irq_out), 32'h0);
        resetn = 1'b1;
        clks(1);
        chk("t1_portb_1clk", 32'(portb_sync), 32'h0);
        clks(1);
        chk("t1_portb_2clk", 32'(portb_sync), 32'haf);
        chk("t1_pending_2clk", 32'(pending), 32'h0);
        irq_pin = 3'b000;
        clks(LAT + 20);
`ifdef IRQ_COND_DEBOUNCE_EN
        chk("t1_short_high_filtered", 32'(pending), 32'h0);
`else
        chk("t1_release_edge", 32'(pending), 32'h7);
`endif
        clear(3'b111);
        chk("t1_cleared", 32'(pending), 32'h0);

        // 2: rising edge on ch0, sticky until cleared
        portb_pin = 8'h5a;
        irq_pin   = 3'b001;
        clks(LAT);
        chk("t2_before_lat", 32'(pending), 32'h0);
        clks(1);
        chk("t2_pending", 32'(pending), 32'h1);
        chk("t2_irq_out", 32'(irq_out), 32'h1);
        clks(18);
        irq_pin = 3'b000;
        clks(30);
        chk("t2_sticky", 32'(pending), 32'h1);
        clear(3'b001);
        chk("t2_clear", 32'(pending), 32'h0);

        // 3: glitch behaviour on ch1
`ifdef IRQ_COND_DEBOUNCE_EN
        irq_pin = 3'b010;
        clks(10);
        irq_pin = 3'b000;
        clks(30);
        chk("t3_glitch_rejected", 32'(pending), 32'h0);
        irq_pin = 3'b010;
        clks(LAT);
        chk("t3_before_18", 32'(pending), 32'h0);
        clks(1);
        chk("t3_at_18", 32'(pending), 32'h2);
        clks(2);
`else
        irq_pin = 3'b010;
        clks(1);
        irq_pin = 3'b000;
        clks(LAT + 2);
        chk("t3_pulse_edge", 32'(pending), 32'h2);
`endif
        irq_pin = 3'b000;
        clks(30);
        clear(3'b010);
        chk("t3_clear", 32'(pending), 32'h0);

        // 4: two edges on ch2 -> overrun
        portb_pin = 8'h3c;
        irq_pin = 3'b100; clks(20);
        irq_pin = 3'b000; clks(20);
        irq_pin = 3'b100; clks(20);
        irq_pin = 3'b000; clks(25);
        chk("t4_pending", 32'(pending), 32'h4);
        chk("t4_overrun", 32'(overrun), 32'h4);
        clear(3'b100);
        chk("t4_clr_pending", 32'(pending), 32'h0);
        chk("t4_clr_overrun", 32'(overrun), 32'h0);

        // 5: clear coinciding with a new edge on ch0
        irq_pin = 3'b001;
        clks(LAT);
        chk("t5_before", 32'(pending), 32'h0);
        clear(3'b001);
        chk("t5_set_wins", 32'(pending), 32'h1);
        chk("t5_no_overrun", 32'(overrun), 32'h0);
        irq_pin = 3'b000;
        clks(30);
        clear(3'b001);
        chk("t5_clear", 32'(pending), 32'h0);

        // 6: enable masks output only
        irq_en  = 3'b101;
        irq_pin = 3'b010;
        clks(LAT + 2);
        chk("t6_pending", 32'(pending), 32'h2);
        chk("t6_masked", 32'(irq_out), 32'h0);
        irq_en = 3'b111;
        #1;
        chk("t6_unmasked", 32'(irq_out), 32'h2);
        irq_pin = 3'b000;
        clks(30);
        clear(3'b111);
        clks(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
